servo_pwm_multi: RTL and testbench



---
 rtl/servo_pwm_multi.sv | 134 +++++++++++++
 tb/tb_servo_pwm_multi.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_multi.sv
`timescale 1ns/1ps
// servo_pwm_multi
//   Multi-channel servo PWM generator. A shared prescaler produces a tick
//   every CLK_DIV clocks; a frame counter divides ticks into frames of
//   FRAME_TICKS. Each channel drives its pin high for act_w ticks at the
//   start of every frame. Commands land in per-channel target registers
//   and are only applied at frame boundaries, optionally slew limited.
//
// Ports
//   clk      system clock
//   rst      synchronous, active-low reset
//   wr_en    command write strobe (one write per cycle)
//   wr_ch    channel index of the write; indices >= NUM_CH are ignored
//   wr_data  command value; pulse width = min(MIN_TICKS + wr_data, MAX_TICKS)
//   ch_en    per-channel enable, sampled at frame boundaries
//   servo_o  registered pulse outputs
//   frame_o  registered one-clock pulse after each frame boundary
//   busy_o   registered, high while active width differs from target
module servo_pwm_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned CLK_DIV     = 120,
    parameter int unsigned FRAME_TICKS = 2000,
    parameter int unsigned MIN_TICKS   = 100,
    parameter int unsigned MAX_TICKS   = 355,
    parameter int unsigned SLEW_STEP   = 0,
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_ch,
    input  logic [DW-1:0]     wr_data,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] servo_o,
    output logic              frame_o,
    output logic [NUM_CH-1:0] busy_o
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TW = $clog2(FRAME_TICKS);
    // One bit wider than either operand so MIN_TICKS + wr_data cannot wrap.
    localparam int unsigned SW = ((DW > TW) ? DW : TW) + 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [TW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [TW-1:0]     tgt_q [NUM_CH];
    logic [TW-1:0]     tgt_d [NUM_CH];
    logic [TW-1:0]     act_q [NUM_CH];
    logic [TW-1:0]     act_d [NUM_CH];
    logic [NUM_CH-1:0] ch_en_act_q, ch_en_act_d;
    logic [NUM_CH-1:0] servo_q, servo_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic              frame_q, frame_d;

    logic              tick;
    logic              boundary;
    logic [SW-1:0]     wr_sum;
    logic [TW-1:0]     wr_width;

    // Next active width: step toward target by at most SLEW_STEP ticks.
    function automatic logic [TW-1:0] slew_toward(input logic [TW-1:0] cur,
                                                  input logic [TW-1:0] tgt);
        logic [TW-1:0] diff;
        diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
        if (SLEW_STEP == 0 || 32'(diff) <= SLEW_STEP) begin
            return tgt;
        end
        return (tgt > cur) ? (cur + TW'(SLEW_STEP)) : (cur - TW'(SLEW_STEP));
    endfunction

    always_comb begin
        tick     = (presc_q == PW'(CLK_DIV - 1));
        boundary = tick && (frame_cnt_q == TW'(FRAME_TICKS - 1));

        presc_d     = tick ? '0 : presc_q + PW'(1);
        frame_cnt_d = frame_cnt_q;
        if (tick) begin
            frame_cnt_d = boundary ? '0 : frame_cnt_q + TW'(1);
        end

        wr_sum   = SW'(MIN_TICKS) + SW'(wr_data);
        wr_width = (wr_sum > SW'(MAX_TICKS)) ? TW'(MAX_TICKS) : wr_sum[TW-1:0];

        ch_en_act_d = boundary ? ch_en : ch_en_act_q;
        frame_d     = boundary;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            tgt_d[i] = tgt_q[i];
            act_d[i] = act_q[i];
            // Boundary reads tgt_q, so a same-cycle write lands one frame later.
            if (boundary) begin
                act_d[i] = slew_toward(act_q[i], tgt_q[i]);
            end
            // An out-of-range wr_ch simply matches no channel.
            if (wr_en && wr_ch == CW'(i)) begin
                tgt_d[i] = wr_width;
            end
            servo_d[i] = ch_en_act_q[i] && (frame_cnt_q < act_q[i]);
            busy_d[i]  = (act_q[i] != tgt_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q     <= '0;
            frame_cnt_q <= '0;
            ch_en_act_q <= '0;
            servo_q     <= '0;
            busy_q      <= '0;
            frame_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= TW'(MIN_TICKS);
                act_q[i] <= TW'(MIN_TICKS);
            end
        end else begin
            presc_q     <= presc_d;
            frame_cnt_q <= frame_cnt_d;
            ch_en_act_q <= ch_en_act_d;
            servo_q     <= servo_d;
            busy_q      <= busy_d;
            frame_q     <= frame_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= tgt_d[i];
                act_q[i] <= act_d[i];
            end
        end
    end

    assign servo_o = servo_q;
    assign frame_o = frame_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
`timescale 1ns/1ps
// Bench for servo_pwm_multi: instance A (4 channels, no slew limit) and
// instance B (5 channels, SLEW_STEP=2) share clock and reset.
module tb_servo_pwm_multi;

    localparam int CLK_DIV     = 4;
    localparam int FRAME_TICKS = 40;
    localparam int MIN_TICKS   = 5;
    localparam int MAX_TICKS   = 20;
    localparam int FRAME       = CLK_DIV * FRAME_TICKS;
    localparam int NA          = 4;
    localparam int NB          = 5;
    localparam int SLEW_B      = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       wr_en_a   = 1'b0;
    logic [1:0] wr_ch_a   = '0;
    logic [7:0] wr_data_a = '0;
    logic [3:0] ch_en_a   = '0;
    logic [3:0] servo_a;
    logic       frame_a;
    logic [3:0] busy_a;

    logic       wr_en_b   = 1'b0;
    logic [2:0] wr_ch_b   = '0;
    logic [7:0] wr_data_b = '0;
    logic [4:0] ch_en_b   = '0;
    logic [4:0] servo_b;
    logic       frame_b;
    logic [4:0] busy_b;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .NUM_CH(NA), .DW(8), .CLK_DIV(CLK_DIV), .FRAME_TICKS(FRAME_TICKS),
        .MIN_TICKS(MIN_TICKS), .MAX_TICKS(MAX_TICKS), .SLEW_STEP(0)
    ) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_ch(wr_ch_a),
        .wr_data(wr_data_a), .ch_en(ch_en_a), .servo_o(servo_a),
        .frame_o(frame_a), .busy_o(busy_a)
    );

    servo_pwm_multi #(
        .NUM_CH(NB), .DW(8), .CLK_DIV(CLK_DIV), .FRAME_TICKS(FRAME_TICKS),
        .MIN_TICKS(MIN_TICKS), .MAX_TICKS(MAX_TICKS), .SLEW_STEP(SLEW_B)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_ch(wr_ch_b),
        .wr_data(wr_data_b), .ch_en(ch_en_b), .servo_o(servo_b),
        .frame_o(frame_b), .busy_o(busy_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: position in the frame is derived from the number
    // of clocks since reset release; widths are plain integers.
    // ------------------------------------------------------------------
    int        m_cyc;
    int        m_tgt [2][16];
    int        m_act [2][16];
    bit [15:0] m_en  [2];
    bit [15:0] e_servo [2];
    bit [15:0] e_busy  [2];
    bit        e_frame;
    int        in_wr [2];
    int        in_ch [2];
    int        in_dat[2];
    bit [15:0] in_en [2];
    int        fc;
    bit        bnd;

    always @(posedge clk) begin
        in_wr[0] = int'(wr_en_a); in_ch[0] = int'(wr_ch_a);
        in_dat[0] = int'(wr_data_a); in_en[0] = 16'(ch_en_a);
        in_wr[1] = int'(wr_en_b); in_ch[1] = int'(wr_ch_b);
        in_dat[1] = int'(wr_data_b); in_en[1] = 16'(ch_en_b);
        if (!rst) begin
            m_cyc   = 0;
            e_frame = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_en[k] = '0; e_servo[k] = '0; e_busy[k] = '0;
                for (int i = 0; i < 16; i++) begin
                    m_tgt[k][i] = MIN_TICKS;
                    m_act[k][i] = MIN_TICKS;
                end
            end
        end else begin
            fc      = (m_cyc / CLK_DIV) % FRAME_TICKS;
            bnd     = (m_cyc % FRAME) == FRAME - 1;
            e_frame = bnd;
            for (int k = 0; k < 2; k++) begin
                int nch;
                int slew;
                nch  = (k == 0) ? NA : NB;
                slew = (k == 0) ? 0 : SLEW_B;
                for (int i = 0; i < nch; i++) begin
                    e_servo[k][i] = m_en[k][i] && (fc < m_act[k][i]);
                    e_busy[k][i]  = (m_act[k][i] != m_tgt[k][i]);
                end
                if (bnd) begin
                    m_en[k] = in_en[k];
                    for (int i = 0; i < nch; i++) begin
                        int diff;
                        diff = m_tgt[k][i] - m_act[k][i];
                        if (slew == 0 || (diff <= slew && diff >= -slew))
                            m_act[k][i] = m_tgt[k][i];
                        else
                            m_act[k][i] += (diff > 0) ? slew : -slew;
                    end
                end
                if (in_wr[k] != 0 && in_ch[k] < nch)
                    m_tgt[k][in_ch[k]] = (MIN_TICKS + in_dat[k] > MAX_TICKS)
                                         ? MAX_TICKS : MIN_TICKS + in_dat[k];
            end
            m_cyc++;
        end
        #1;
        check("model_servo_a", int'(servo_a), int'(e_servo[0][3:0]));
        check("model_busy_a",  int'(busy_a),  int'(e_busy[0][3:0]));
        check("model_frame_a", int'(frame_a), int'(e_frame));
        check("model_servo_b", int'(servo_b), int'(e_servo[1][4:0]));
        check("model_busy_b",  int'(busy_b),  int'(e_busy[1][4:0]));
        check("model_frame_b", int'(frame_b), int'(e_frame));
    end

    // ------------------------------------------------------------------
    // Directed measurement helpers (run on negedges).
    // ------------------------------------------------------------------
    int       hi_a [NA];
    int       first_a [NA];
    int       hi_b [NB];
    int       frames_in;
    logic [4:0] busy_mid_b;
    int       wait_hi;

    task automatic wait_frame(output int n);
        n = 0;
        wait_hi = 0;
        do begin
            @(negedge clk);
            n++;
            wait_hi += $countones(servo_a) + $countones(servo_b);
        end while (!frame_a && n < 3 * FRAME);
        if (!frame_a) begin
            checks++;
            errors++;
            $display("FAIL frame_wait: no frame_o within %0d cycles, expected within %0d", n, FRAME);
        end
    endtask

    task automatic count_frame();
        for (int i = 0; i < NA; i++) begin hi_a[i] = 0; first_a[i] = 0; end
        for (int i = 0; i < NB; i++) hi_b[i] = 0;
        frames_in = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            for (int i = 0; i < NA; i++) begin
                if (servo_a[i]) begin
                    hi_a[i]++;
                    if (first_a[i] == 0) first_a[i] = k;
                end
            end
            for (int i = 0; i < NB; i++) if (servo_b[i]) hi_b[i]++;
            if (frame_a) frames_in++;
            if (k == FRAME / 2) busy_mid_b = busy_b;
        end
    endtask

    task automatic check_hi_a(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
        check({tag, "_hi_a0"}, hi_a[0], e0);
        check({tag, "_hi_a1"}, hi_a[1], e1);
        check({tag, "_hi_a2"}, hi_a[2], e2);
        check({tag, "_hi_a3"}, hi_a[3], e3);
    endtask

    task automatic write_a(input int ch, input int data);
        wr_en_a = 1'b1; wr_ch_a = 2'(ch); wr_data_a = 8'(data);
        @(negedge clk);
        wr_en_a = 1'b0;
    endtask

    task automatic write_b(input int ch, input int data);
        wr_en_b = 1'b1; wr_ch_b = 3'(ch); wr_data_b = 8'(data);
        @(negedge clk);
        wr_en_b = 1'b0;
    endtask

    int n;
    int slew_hi   [5] = '{28, 36, 44, 52, 60};
    int slew_busy [5] = '{1, 1, 1, 1, 0};

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_servo_a", int'(servo_a), 0);
        check("rst_frame_a", int'(frame_a), 0);
        check("rst_busy_b",  int'(busy_b),  0);
        rst = 1'b1;

        // Idle: frame period, no pulses, not busy
        wait_frame(n);
        check("t1_first_boundary", n, FRAME);
        check("t1_first_frame_hi", wait_hi, 0);
        count_frame();
        check("t1_frame_period_end", int'(frame_a), 1);
        check("t1_frames_in_period", frames_in, 1);
        check_hi_a("t1", 0, 0, 0, 0);
        check("t1_busy_a", int'(busy_a), 0);

        // Single channel enabled: 7 -> width 12 -> 48 clk
        write_a(1, 7);
        ch_en_a = 4'b0010;
        wait_frame(n);
        count_frame();
        check_hi_a("t2", 0, 48, 0, 0);
        check("t2_rise_ch1", first_a[1], 1);

        // Clamping and reset width on untouched channel
        write_a(2, 200);
        write_a(3, 0);
        ch_en_a = 4'hF;
        wait_frame(n);
        count_frame();
        check_hi_a("t3", 20, 48, 80, 20);

        // Last write wins; write on the boundary cycle applies one frame later
        wr_en_a = 1'b1; wr_ch_a = 2'd0; wr_data_a = 8'd3;
        @(negedge clk); wr_data_a = 8'd9;
        @(negedge clk); wr_data_a = 8'd1;
        @(negedge clk); wr_en_a = 1'b0;
        repeat (FRAME - 4) @(negedge clk);
        wr_en_a = 1'b1; wr_data_a = 8'd4;
        @(negedge clk);
        wr_en_a = 1'b0;
        check("t4_boundary_aligned", int'(frame_a), 1);
        count_frame();
        check_hi_a("t4a", 24, 48, 80, 20);
        count_frame();
        check_hi_a("t4b", 36, 48, 80, 20);

        // Instance B: out-of-range channel writes are ignored
        ch_en_b = 5'h1F;
        wait_frame(n);
        count_frame();
        write_b(5, 100);
        write_b(6, 0);
        write_b(7, 255);
        wait_frame(n);
        count_frame();
        for (int i = 0; i < NB; i++) check($sformatf("t5_hi_b%0d", i), hi_b[i], 20);
        check("t5_busy_b", int'(busy_mid_b), 0);

        // Slew-limited ramp 5 -> 15 in steps of 2
        write_b(0, 10);
        @(negedge clk);
        check("t6_busy_after_write", int'(busy_b[0]), 1);
        wait_frame(n);
        for (int f = 0; f < 5; f++) begin
            count_frame();
            check($sformatf("t6_hi_b0_f%0d", f), hi_b[0], slew_hi[f]);
            check($sformatf("t6_busy_b0_f%0d", f), int'(busy_mid_b[0]), slew_busy[f]);
            check($sformatf("t6_hi_b1_f%0d", f), hi_b[1], 20);
        end

        // Reset mid-pulse
        repeat (10) @(negedge clk);
        check("t7_pre_servo_a", int'(servo_a), 15);
        check("t7_pre_servo_b", int'(servo_b), 31);
        rst = 1'b0;
        @(negedge clk);
        check("t7_rst_servo_a", int'(servo_a), 0);
        check("t7_rst_servo_b", int'(servo_b), 0);
        check("t7_rst_frame_a", int'(frame_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_frame(n);
        check("t7_first_boundary", n, FRAME);
        check("t7_first_frame_hi", wait_hi, 0);
        count_frame();
        check_hi_a("t7", 20, 20, 20, 20);
        for (int i = 0; i < NB; i++) check($sformatf("t7_hi_b%0d", i), hi_b[i], 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
